// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, carry held in a flop between bits.
// Operands enter and results leave over valid/ready handshakes, LSB first.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] DONE  = 2'b10;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_next;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic s1;
   logic c1;
   logic fa_bit;
   logic c2;
   logic c_next;

   // Full adder built from two half adders and an OR of their carries.
   always_comb begin
      s1     = a_sh[0] ^ b_sh[0];
      c1     = a_sh[0] & b_sh[0];
      fa_bit = s1 ^ carry;
      c2     = s1 & carry;
      c_next = c1 | c2;
   end

   // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_one
         assign sum_next = fa_bit;
      end else begin : g_many
         assign sum_next = {fa_bit, sum_sh[WIDTH-1:1]};
      end
   endgenerate

   // Handshake and status flags decode straight from the state register.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state == SHIFT) || (state == DONE);
      sum       = sum_sh;
   end

   // Control FSM plus the operand, sum and carry datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               carry  <= c_next;
               sum_sh <= sum_next;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cout  <= c_next;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
